// File: rtl/bwt_align_pkg.sv
// Shared definitions for the multi-lane match run counter.
//   - lane_state_t : per-lane FSM state (IDLE / RUN / HIT), 2-bit encoding
//   - width/size localparams for lanes, run counter, miss counter, lane index
//   - sat_inc      : run counter increment that saturates at TAGT_NUM
//   - clamp_thresh : maps out-of-range thresholds onto TAGT_NUM
package bwt_align_pkg;

  localparam int NUM_CH   = 4;
  localparam int TAGT_NUM = 64;
  localparam int CNT_W    = 7;
  localparam int MISS_W   = 2;
  localparam int CH_W     = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HIT  = 2'd2
  } lane_state_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (c >= CNT_W'(TAGT_NUM)) return CNT_W'(TAGT_NUM);
    return c + 1'b1;
  endfunction

  function automatic logic [CNT_W-1:0] clamp_thresh(input logic [CNT_W-1:0] t);
    if (t > CNT_W'(TAGT_NUM)) return CNT_W'(TAGT_NUM);
    return t;
  endfunction

endpackage

// File: rtl/match_run_lane.sv
// One lane of the match run counter.
// Ports:
//   clk       : clock, all state on posedge
//   valid     : synchronous active-low clear of the lane
//   in_vld    : a base compare is presented this cycle
//   in_match  : this lane's compare result (used only when in_vld=1)
//   thresh    : hit threshold (values above TAGT_NUM act as TAGT_NUM)
//   max_miss  : mismatches tolerated per run
//   mode      : 0 = one-cycle hit then restart, 1 = hit sticks until clear
//   state     : registered FSM state (also the debug view of the lane)
//   cnt       : registered run length
module match_run_lane
  import bwt_align_pkg::*;
(
  input  logic              clk,
  input  logic              valid,
  input  logic              in_vld,
  input  logic              in_match,
  input  logic [CNT_W-1:0]  thresh,
  input  logic [MISS_W-1:0] max_miss,
  input  logic              mode,
  output lane_state_t       state,
  output logic [CNT_W-1:0]  cnt
);

  logic [MISS_W-1:0] miss;
  logic [CNT_W-1:0]  th_eff;
  logic [CNT_W-1:0]  cnt_nxt;

  assign th_eff  = clamp_thresh(thresh);
  assign cnt_nxt = sat_inc(cnt);

  always_ff @(posedge clk) begin
    if (!valid) begin
      state <= ST_IDLE;
      cnt   <= '0;
      miss  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_vld) begin
            if (in_match) begin
              cnt   <= CNT_W'(1);
              miss  <= '0;
              state <= (th_eff <= CNT_W'(1)) ? ST_HIT : ST_RUN;
            end else begin
              cnt <= '0;
            end
          end
        end
        ST_RUN: begin
          if (in_vld) begin
            // A tolerated mismatch still advances the position count and
            // takes part in the threshold check, exactly like a match.
            if (in_match || (miss < max_miss)) begin
              cnt   <= cnt_nxt;
              state <= (cnt_nxt >= th_eff) ? ST_HIT : ST_RUN;
              if (!in_match) miss <= miss + 1'b1;
            end else begin
              state <= ST_IDLE;
              cnt   <= '0;
              miss  <= '0;
            end
          end
        end
        ST_HIT: begin
          // Mode 0 leaves HIT regardless of in_vld; any base presented in
          // the hit cycle is dropped. Mode 1 freezes everything.
          if (!mode) begin
            state <= ST_IDLE;
            cnt   <= '0;
            miss  <= '0;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
          miss  <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/match_run_counter.sv
// Multi-lane match run counter: NUM_CH independent lanes sharing one base
// strobe, each counting aligned positions and flagging a hit at threshold.
// Ports:
//   clk       : clock
//   valid     : synchronous active-low clear of all lanes
//   in_vld    : a base compare is presented this cycle (all lanes)
//   in_match  : per-lane compare result
//   thresh    : hit threshold, 1..TAGT_NUM (larger values act as TAGT_NUM)
//   max_miss  : mismatches tolerated per run
//   mode      : 0 = pulse-and-restart on hit, 1 = sticky hit
//   en1       : lane is mid-run
//   en2       : lane hit
//   run_len   : packed per-lane counts, lane k at [k*CNT_W +: CNT_W]
//   any_hit   : OR of en2
//   hit_ch    : lowest lane index with en2 set, 0 when none
module match_run_counter
  import bwt_align_pkg::*;
(
  input  logic                    clk,
  input  logic                    valid,
  input  logic                    in_vld,
  input  logic [NUM_CH-1:0]       in_match,
  input  logic [CNT_W-1:0]        thresh,
  input  logic [MISS_W-1:0]       max_miss,
  input  logic                    mode,
  output logic [NUM_CH-1:0]       en1,
  output logic [NUM_CH-1:0]       en2,
  output logic [NUM_CH*CNT_W-1:0] run_len,
  output logic                    any_hit,
  output logic [CH_W-1:0]         hit_ch
);

  lane_state_t lane_state [NUM_CH];

  for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
    match_run_lane u_lane (
      .clk      (clk),
      .valid    (valid),
      .in_vld   (in_vld),
      .in_match (in_match[k]),
      .thresh   (thresh),
      .max_miss (max_miss),
      .mode     (mode),
      .state    (lane_state[k]),
      .cnt      (run_len[k*CNT_W +: CNT_W])
    );

    // Pure decodes of the state flops, so en1/en2 change only at the edge.
    assign en1[k] = (lane_state[k] == ST_RUN);
    assign en2[k] = (lane_state[k] == ST_HIT);
  end

  assign any_hit = |en2;

  // Scan from the top down so the lowest set lane wins.
  always_comb begin
    hit_ch = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (en2[k]) hit_ch = CH_W'(k);
    end
  end

endmodule

// File: tb/tb_match_run_counter.sv
module tb_match_run_counter;
  import bwt_align_pkg::*;

  localparam int W = NUM_CH + NUM_CH + NUM_CH*CNT_W + 1 + CH_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                    valid;
  logic                    in_vld;
  logic [NUM_CH-1:0]       in_match;
  logic [CNT_W-1:0]        thresh;
  logic [MISS_W-1:0]       max_miss;
  logic                    mode;
  logic [NUM_CH-1:0]       en1;
  logic [NUM_CH-1:0]       en2;
  logic [NUM_CH*CNT_W-1:0] run_len;
  logic                    any_hit;
  logic [CH_W-1:0]         hit_ch;

  match_run_counter dut (
    .clk      (clk),
    .valid    (valid),
    .in_vld   (in_vld),
    .in_match (in_match),
    .thresh   (thresh),
    .max_miss (max_miss),
    .mode     (mode),
    .en1      (en1),
    .en2      (en2),
    .run_len  (run_len),
    .any_hit  (any_hit),
    .hit_ch   (hit_ch)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Each lane is described by what it is doing (0 waiting, 1 counting,
  // 2 reporting a hit), how many positions it has counted and how many
  // mismatches it has spent.
  int ph    [NUM_CH];
  int count [NUM_CH];
  int spent [NUM_CH];

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic void model_step();
    int lim;
    lim = min_i(int'(thresh), TAGT_NUM);
    for (int k = 0; k < NUM_CH; k++) begin
      if (!valid) begin
        ph[k] = 0; count[k] = 0; spent[k] = 0;
      end else if (ph[k] == 2) begin
        if (!mode) begin ph[k] = 0; count[k] = 0; spent[k] = 0; end
      end else if (in_vld) begin
        if (ph[k] == 0) begin
          if (in_match[k]) begin
            count[k] = 1; spent[k] = 0; ph[k] = (count[k] >= lim) ? 2 : 1;
          end else begin
            count[k] = 0;
          end
        end else begin
          if (in_match[k] || spent[k] < int'(max_miss)) begin
            if (!in_match[k]) spent[k]++;
            count[k] = min_i(count[k] + 1, TAGT_NUM);
            ph[k] = (count[k] >= lim) ? 2 : 1;
          end else begin
            ph[k] = 0; count[k] = 0; spent[k] = 0;
          end
        end
      end
    end
  endfunction

  function automatic logic [W-1:0] model_outputs();
    logic [NUM_CH-1:0]       e1, e2;
    logic [NUM_CH*CNT_W-1:0] rl;
    logic                    ah;
    logic [CH_W-1:0]         hc;
    int first;
    first = -1;
    for (int k = 0; k < NUM_CH; k++) begin
      e1[k] = (ph[k] == 1);
      e2[k] = (ph[k] == 2);
      rl[k*CNT_W +: CNT_W] = CNT_W'(count[k]);
      if (ph[k] == 2 && first < 0) first = k;
    end
    ah = (first >= 0);
    hc = (first >= 0) ? CH_W'(first) : '0;
    return {e1, e2, rl, ah, hc};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic cycle();
    logic [W-1:0] e;
    @(posedge clk);
    model_step();
    exp_q.push_back(model_outputs());
    #1;
    e = exp_q.pop_front();
    check("en1",     32'(en1),     32'(e[W-1 -: NUM_CH]));
    check("en2",     32'(en2),     32'(e[W-NUM_CH-1 -: NUM_CH]));
    for (int k = 0; k < NUM_CH; k++)
      check($sformatf("run_len%0d", k), 32'(run_len[k*CNT_W +: CNT_W]),
            32'(e[CH_W+1+k*CNT_W +: CNT_W]));
    check("any_hit", 32'(any_hit), 32'(e[CH_W]));
    check("hit_ch",  32'(hit_ch),  32'(e[CH_W-1:0]));
  endtask

  task automatic base(input logic [NUM_CH-1:0] m);
    valid = 1'b1; in_vld = 1'b1; in_match = m;
    cycle();
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      valid = 1'b1; in_vld = 1'b0; in_match = 4'($urandom_range(0, 15));
      cycle();
    end
  endtask

  task automatic clear(input int n);
    for (int i = 0; i < n; i++) begin
      valid = 1'b0; in_vld = 1'b1; in_match = '1;
      cycle();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int k = 0; k < NUM_CH; k++) begin ph[k] = 0; count[k] = 0; spent[k] = 0; end
    valid = 1'b0; in_vld = 1'b1; in_match = '1;
    thresh = 7'd5; max_miss = 2'd0; mode = 1'b0;

    // Reset held with live inputs.
    clear(3);
    check("rst_en2", 32'(en2), 32'd0);
    check("rst_run_len", 32'(run_len[31:0]), 32'd0);

    // Clean run to threshold 5, pulse hit.
    thresh = 7'd5; max_miss = 2'd0; mode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      base(4'b0001);
      check("clean_en1", 32'(en1[0]), 32'd1);
    end
    base(4'b0001);
    check("clean_hit", 32'(en2[0]), 32'd1);
    check("clean_len", 32'(run_len[0 +: CNT_W]), 32'd5);
    gap(1);
    check("clean_idle_len", 32'(run_len[0 +: CNT_W]), 32'd0);

    // Tolerance on lane 1: M M X M X M X ends the run.
    clear(1);
    thresh = 7'd8; max_miss = 2'd2;
    base(4'b0010); base(4'b0010); base(4'b0000); base(4'b0010);
    base(4'b0000); base(4'b0010); base(4'b0000);
    check("tol_drop_len", 32'(run_len[CNT_W +: CNT_W]), 32'd0);
    check("tol_drop_en1", 32'(en1[1]), 32'd0);
    // M M X M X M M M reaches 8.
    base(4'b0010); base(4'b0010); base(4'b0000); base(4'b0010);
    base(4'b0000); base(4'b0010); base(4'b0010); base(4'b0010);
    check("tol_hit", 32'(en2[1]), 32'd1);

    // Sticky hit on lane 2, then a mid-operation clear.
    clear(1);
    mode = 1'b1; thresh = 7'd3; max_miss = 2'd0;
    base(4'b0100); base(4'b0100); base(4'b0100);
    for (int i = 0; i < 10; i++) base(4'($urandom_range(0, 15)));
    check("sticky_en2", 32'(en2[2]), 32'd1);
    check("sticky_len", 32'(run_len[2*CNT_W +: CNT_W]), 32'd3);
    clear(1);
    check("sticky_clr", 32'({en1, en2, any_hit}), 32'd0);

    // Simultaneous hits on lanes 1 and 3.
    mode = 1'b0; thresh = 7'd3;
    base(4'b1010); base(4'b1010); base(4'b1010);
    check("simul_hit_ch", 32'(hit_ch), 32'd1);
    check("simul_any", 32'(any_hit), 32'd1);
    gap(1);

    // thresh=1 hits on the first match; mode 1 -> 0 leaves HIT next edge.
    thresh = 7'd1; mode = 1'b1;
    base(4'b1000);
    check("th1_hit", 32'(hit_ch), 32'd3);
    mode = 1'b0;
    gap(2);

    // Full-length run, no wrap past TAGT_NUM.
    clear(1);
    thresh = 7'(TAGT_NUM); mode = 1'b1;
    for (int i = 0; i < TAGT_NUM; i++) base(4'b0001);
    check("full_hit", 32'(en2[0]), 32'd1);
    base(4'b0001); base(4'b0001);
    check("full_len", 32'(run_len[0 +: CNT_W]), 32'(TAGT_NUM));

    // Gaps mid-run hold state; lowering thresh hits on the next base.
    clear(1);
    mode = 1'b0; thresh = 7'd10;
    for (int i = 0; i < 3; i++) base(4'b0001);
    gap(5);
    for (int i = 0; i < 3; i++) base(4'b0001);
    check("gap_len", 32'(run_len[0 +: CNT_W]), 32'd6);
    thresh = 7'd3;
    gap(1);
    check("lower_no_hit", 32'(en2[0]), 32'd0);
    base(4'b0001);
    check("lower_hit", 32'(en2[0]), 32'd1);
    check("lower_len", 32'(run_len[0 +: CNT_W]), 32'd7);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) thresh = 7'($urandom_range(1, 70));
      else if ($urandom_range(0, 9) == 0) thresh = 7'($urandom_range(1, 12));
      if ($urandom_range(0, 29) == 0) max_miss = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) mode = 1'($urandom_range(0, 1));
      valid  = ($urandom_range(0, 99) != 0);
      in_vld = ($urandom_range(0, 3) != 0);
      for (int k = 0; k < NUM_CH; k++) in_match[k] = ($urandom_range(0, 4) != 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
